// File: rtl/ex_mem_reg_pkg.sv
// Shared constants, default widths and the one-hot stage action type
// used by ex_mem_reg and the other pipeline stage registers.
package ex_mem_reg_pkg;

   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_REG_AW  = 5;
   localparam int unsigned DEF_OP_W    = 8;
   localparam int unsigned DEF_STALL_W = 6;
   localparam int unsigned DEF_STAGE   = 2;

   localparam logic STOP          = 1'b1;
   localparam logic NOT_STOP      = 1'b0;
   localparam logic RST_ENABLE    = 1'b1;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   typedef enum logic [4:0] {
      ACT_RST     = 5'b00001,
      ACT_FLUSH   = 5'b00010,
      ACT_BUBBLE  = 5'b00100,
      ACT_ADVANCE = 5'b01000,
      ACT_HOLD    = 5'b10000
   } stage_act_e;

endpackage

// File: rtl/ex_mem_reg_stage_ctl.sv
// stage_ctl: decodes reset, flush and the two neighbouring stall bits into a
// single one-hot stage action. Stall on the upstream side only wins as a bubble.
module stage_ctl
   import ex_mem_reg_pkg::*;
(
   input  logic       rst,
   input  logic       flush_i,
   input  logic       stall_prev,
   input  logic       stall_this,
   output stage_act_e act_o
);

   always_comb begin
      act_o = ACT_HOLD;
      if (rst == RST_ENABLE) begin
         act_o = ACT_RST;
      end else if (flush_i) begin
         act_o = ACT_FLUSH;
      end else if (stall_prev == NOT_STOP) begin
         // Upstream running with this stage stopped cannot occur; take it as advance.
         act_o = ACT_ADVANCE;
      end else if (stall_prev == STOP && stall_this == NOT_STOP) begin
         act_o = ACT_BUBBLE;
      end else begin
         act_o = ACT_HOLD;
      end
   end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall/flush handling and MADD/MSUB feedback.
// HI/LO fields and accumulate feedback are built only when EX_MEM_HILO_EN is defined.
module ex_mem_reg
   import ex_mem_reg_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned REG_AW  = DEF_REG_AW,
   parameter int unsigned OP_W    = DEF_OP_W,
   parameter int unsigned STALL_W = DEF_STALL_W,
   parameter int unsigned STAGE   = DEF_STAGE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STALL_W-1:0]    stall_i,
   input  logic                  flush_i,
   input  logic                  ex_we,
   input  logic [REG_AW-1:0]     ex_waddr,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic [OP_W-1:0]       ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_store_data,
   input  logic                  ex_whilo,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   input  logic [2*DATA_W-1:0]   ex_hilo_tmp,
   input  logic [1:0]            ex_cnt,
   output logic                  mem_valid,
   output logic                  mem_we,
   output logic [REG_AW-1:0]     mem_waddr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [OP_W-1:0]       mem_aluop,
   output logic [DATA_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_store_data,
   output logic                  mem_whilo,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic [2*DATA_W-1:0]   hilo_tmp_o,
   output logic [1:0]            cnt_o
);

   stage_act_e act;

   logic                valid_q, valid_d;
   logic                we_q, we_d;
   logic [REG_AW-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [OP_W-1:0]     aluop_q, aluop_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   sdata_q, sdata_d;

   logic unused_stall;
   assign unused_stall = ^stall_i;

   stage_ctl u_stage_ctl (
      .rst        (rst),
      .flush_i    (flush_i),
      .stall_prev (stall_i[STAGE-1]),
      .stall_this (stall_i[STAGE]),
      .act_o      (act)
   );

   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      aluop_d = aluop_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      unique case (act)
         ACT_RST, ACT_FLUSH, ACT_BUBBLE: begin
            valid_d = WRITE_DISABLE;
            we_d    = WRITE_DISABLE;
            waddr_d = '0;
            wdata_d = '0;
            aluop_d = '0;
            addr_d  = '0;
            sdata_d = '0;
         end
         ACT_ADVANCE: begin
            valid_d = WRITE_ENABLE;
            we_d    = ex_we;
            waddr_d = ex_waddr;
            wdata_d = ex_wdata;
            aluop_d = ex_aluop;
            addr_d  = ex_mem_addr;
            sdata_d = ex_store_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         valid_q <= '0;
         we_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         aluop_q <= '0;
         addr_q  <= '0;
         sdata_q <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         aluop_q <= aluop_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
      end
   end

   assign mem_valid      = valid_q;
   assign mem_we         = we_q;
   assign mem_waddr      = waddr_q;
   assign mem_wdata      = wdata_q;
   assign mem_aluop      = aluop_q;
   assign mem_addr       = addr_q;
   assign mem_store_data = sdata_q;

`ifdef EX_MEM_HILO_EN
   logic                whilo_q, whilo_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [2*DATA_W-1:0] hilo_tmp_q, hilo_tmp_d;
   logic [1:0]          cnt_q, cnt_d;

   // A bubble captures the partial accumulate so EX sees it next cycle.
   always_comb begin
      whilo_d    = whilo_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      hilo_tmp_d = hilo_tmp_q;
      cnt_d      = cnt_q;
      unique case (act)
         ACT_RST, ACT_FLUSH: begin
            whilo_d    = WRITE_DISABLE;
            hi_d       = '0;
            lo_d       = '0;
            hilo_tmp_d = '0;
            cnt_d      = '0;
         end
         ACT_BUBBLE: begin
            whilo_d    = WRITE_DISABLE;
            hi_d       = '0;
            lo_d       = '0;
            hilo_tmp_d = ex_hilo_tmp;
            cnt_d      = ex_cnt;
         end
         ACT_ADVANCE: begin
            whilo_d    = ex_whilo;
            hi_d       = ex_hi;
            lo_d       = ex_lo;
            hilo_tmp_d = '0;
            cnt_d      = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         whilo_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         hilo_tmp_q <= '0;
         cnt_q      <= '0;
      end else begin
         whilo_q    <= whilo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         hilo_tmp_q <= hilo_tmp_d;
         cnt_q      <= cnt_d;
      end
   end

   assign mem_whilo  = whilo_q;
   assign mem_hi     = hi_q;
   assign mem_lo     = lo_q;
   assign hilo_tmp_o = hilo_tmp_q;
   assign cnt_o      = cnt_q;
`else
   logic unused_hilo;
   assign unused_hilo = ^{ex_whilo, ex_hi, ex_lo, ex_hilo_tmp, ex_cnt};

   assign mem_whilo  = 1'b0;
   assign mem_hi     = '0;
   assign mem_lo     = '0;
   assign hilo_tmp_o = '0;
   assign cnt_o      = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized bench for ex_mem_reg against a stage-action reference model;
// expects HI/LO outputs to stay 0 unless EX_MEM_HILO_EN is defined.
module tb_ex_mem_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        ex_we;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata, ex_aluop_w, ex_mem_addr, ex_store_data, ex_hi, ex_lo;
   logic [7:0]  ex_aluop;
   logic        ex_whilo;
   logic [63:0] ex_hilo_tmp;
   logic [1:0]  ex_cnt;

   logic        mem_valid, mem_we, mem_whilo;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata, mem_addr, mem_store_data, mem_hi, mem_lo;
   logic [7:0]  mem_aluop;
   logic [63:0] hilo_tmp_o;
   logic [1:0]  cnt_o;

   // reference state
   logic        m_valid, m_we, m_whilo;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata, m_addr, m_sd, m_hi, m_lo;
   logic [7:0]  m_aluop;
   logic [63:0] m_tmp;
   logic [1:0]  m_cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   ex_mem_reg #(.DATA_W(32), .REG_AW(5), .OP_W(8), .STALL_W(6), .STAGE(2)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
      .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
      .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .hilo_tmp_o(hilo_tmp_o), .cnt_o(cnt_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_model();
      {m_valid, m_we, m_whilo, m_waddr, m_wdata, m_addr, m_sd, m_hi, m_lo, m_aluop, m_tmp, m_cnt} = '0;
   endtask

   // Reference: pick the action from the stage rules, then apply it.
   task automatic model_edge();
      bit hilo_en;
`ifdef EX_MEM_HILO_EN
      hilo_en = 1'b1;
`else
      hilo_en = 1'b0;
`endif
      if (rst || flush_i) begin
         clear_model();
      end else if (!stall_i[1]) begin
         m_valid = 1; m_we = ex_we; m_waddr = ex_waddr; m_wdata = ex_wdata;
         m_aluop = ex_aluop; m_addr = ex_mem_addr; m_sd = ex_store_data;
         m_whilo = ex_whilo; m_hi = ex_hi; m_lo = ex_lo; m_tmp = 0; m_cnt = 0;
      end else if (!stall_i[2]) begin
         clear_model();
         m_tmp = ex_hilo_tmp; m_cnt = ex_cnt;
      end
      if (!hilo_en) begin
         m_whilo = 0; m_hi = 0; m_lo = 0; m_tmp = 0; m_cnt = 0;
      end
   endtask

   task automatic check_all(input string ph);
      check_eq({ph, ".valid"}, 64'(mem_valid), 64'(m_valid));
      check_eq({ph, ".we"},    64'(mem_we), 64'(m_we));
      check_eq({ph, ".waddr"}, 64'(mem_waddr), 64'(m_waddr));
      check_eq({ph, ".wdata"}, 64'(mem_wdata), 64'(m_wdata));
      check_eq({ph, ".aluop"}, 64'(mem_aluop), 64'(m_aluop));
      check_eq({ph, ".addr"},  64'(mem_addr), 64'(m_addr));
      check_eq({ph, ".sdata"}, 64'(mem_store_data), 64'(m_sd));
      check_eq({ph, ".whilo"}, 64'(mem_whilo), 64'(m_whilo));
      check_eq({ph, ".hi"},    64'(mem_hi), 64'(m_hi));
      check_eq({ph, ".lo"},    64'(mem_lo), 64'(m_lo));
      check_eq({ph, ".tmp"},   hilo_tmp_o, m_tmp);
      check_eq({ph, ".cnt"},   64'(cnt_o), 64'(m_cnt));
   endtask

   task automatic rand_ex();
      ex_we = 1'($urandom); ex_waddr = 5'($urandom); ex_wdata = $urandom;
      ex_aluop = 8'($urandom); ex_mem_addr = $urandom; ex_store_data = $urandom;
      ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
      ex_hilo_tmp = {$urandom, $urandom}; ex_cnt = 2'($urandom);
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      check_all(ph);
   endtask

   initial begin
      ex_aluop_w = '0;
      rst = 1; flush_i = 0; stall_i = '0;
      rand_ex();
      clear_model();
      #1;
      step("rst0");
      step("rst1");
      check_eq("rst.valid_zero", 64'(mem_valid), 64'd0);

      // Reset then advance
      rst = 0;
      ex_we = 1; ex_waddr = 5'h1F; ex_wdata = 32'hDEADBEEF;
      step("adv");
      check_eq("adv.wdata_const", 64'(mem_wdata), 64'hDEADBEEF);
      check_eq("adv.valid_one", 64'(mem_valid), 64'd1);

      // Bubble carrying accumulate state
      stall_i = 6'b000010; ex_cnt = 2'b01; ex_hilo_tmp = 64'h0000_0001_0000_0002;
      step("bub");
      check_eq("bub.we_zero", 64'(mem_we), 64'd0);

      // Advance so hold has something non-zero to freeze, then hold 3 cycles
      stall_i = '0; rand_ex(); step("adv2");
      stall_i = 6'b000110;
      for (int i = 0; i < 3; i++) begin
         rand_ex();
         step("hold");
      end

      // Flush over stall, and mid-accumulate flush
      stall_i = 6'b000010; rand_ex(); flush_i = 0;
      stall_i = 6'b000110; flush_i = 1; step("flush");
      check_eq("flush.cnt_zero", 64'(cnt_o), 64'd0);
      flush_i = 0; stall_i = 6'b000010; ex_cnt = 2'b10; step("bub2");
      flush_i = 1; step("flush_acc");

      // Two-cycle MADD: bubble then advance
      flush_i = 0;
      stall_i = 6'b000010; ex_cnt = 2'b01; ex_hilo_tmp = 64'h5; step("madd1");
      stall_i = 6'b000000; ex_whilo = 1; ex_hi = 32'h1; ex_lo = 32'h2; ex_cnt = 2'b00;
      step("madd2");

      // Reset mid-hold
      stall_i = 6'b000110; step("hold2");
      rst = 1; step("rst_hold");
      rst = 0;

      // Illegal combination treated as advance
      stall_i = 6'b000100; rand_ex(); step("illegal");

      // Randomized run with weighted stall/flush/reset
      for (int i = 0; i < 400; i++) begin
         int unsigned r;
         rand_ex();
         r = $urandom_range(0, 15);
         stall_i = 6'($urandom) & 6'b111001;
         case (r)
            0, 1, 2: stall_i[2:1] = 2'b01;
            3, 4:    stall_i[2:1] = 2'b11;
            5:       stall_i[2:1] = 2'b10;
            default: stall_i[2:1] = 2'b00;
         endcase
         flush_i = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 39) == 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Parametrised EX→MEM pipeline register; successor to the fixed-width EX/MEM latch. Carries the register write-back fields, memory-access fields and HI/LO write fields from EX to MEM. Honours the global stall vector and a pipeline flush. Feeds the multi-cycle accumulate state (`hilo_tmp`, `cnt`) back to EX so two-cycle MADD/MSUB sequences survive the bubble they insert.

## Interface
Parameters:
- `DATA_W`, 32: GPR/HI/LO/memory data width.
- `REG_AW`, 5: register-file address width.
- `OP_W`, 8: ALU/memory opcode width.
- `STALL_W`, 6: stall vector width.
- `STAGE`, 2: stall-vector index of MEM; EX is `STAGE-1`. Legal range 1..STALL_W-1.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `stall_i`, in, STALL_W: per-stage stop bits; 1 = Stop.
- `flush_i`, in, 1: exception flush; clears the stage.
- `ex_we`, `ex_waddr`, `ex_wdata`, in, 1/REG_AW/DATA_W: GPR write request.
- `ex_aluop`, in, OP_W: opcode forwarded for the MEM access.
- `ex_mem_addr`, `ex_store_data`, in, DATA_W each: load/store address and store data.
- `ex_whilo`, `ex_hi`, `ex_lo`, in, 1/DATA_W/DATA_W: HI/LO write request.
- `ex_hilo_tmp`, `ex_cnt`, in, 2·DATA_W/2: partial accumulate result and step count from EX.
- `mem_valid`, out, 1: MEM holds a real instruction.
- `mem_we`, `mem_waddr`, `mem_wdata`, `mem_aluop`, `mem_addr`, `mem_store_data`, `mem_whilo`, `mem_hi`, `mem_lo`, out: registered copies of the `ex_*` inputs.
- `hilo_tmp_o`, `cnt_o`, out, 2·DATA_W/2: feedback to EX.

## Operation
Each cycle selects exactly one action, in this priority order:
1. **Reset** (`rst`=1): every output goes to 0.
2. **Flush** (`flush_i`=1): every output goes to 0, regardless of stall.
3. **Bubble** (`stall_i[STAGE-1]`=1 and `stall_i[STAGE]`=0):
   - Pipeline outputs go to 0 and `mem_valid`=0.
   - `hilo_tmp_o` ← `ex_hilo_tmp`; `cnt_o` ← `ex_cnt`.
4. **Advance** (`stall_i[STAGE-1]`=0):
   - All `mem_*` outputs load their `ex_*` inputs; `mem_valid`=1.
   - `hilo_tmp_o` ← 0; `cnt_o` ← 0.
5. **Hold** (both stall bits 1): every register keeps its value.

Further rules:
- Case `stall_i[STAGE-1]`=0 with `stall_i[STAGE]`=1 is illegal; the stall controller never produces it. The block treats it as Advance.
- No arithmetic is performed; widths pass straight through.

## Timing
- Latency EX→MEM is 1 cycle.
- Feedback `hilo_tmp_o`/`cnt_o` is visible to EX in the cycle after a Bubble.
- A flush asserted mid-accumulate clears `cnt_o` and `hilo_tmp_o` in the same edge; a restarted MADD begins from `cnt`=0.
- Reset mid-hold clears everything.
- Outputs are purely registered; there is no combinational input→output path.

## Configuration
- Macro `EX_MEM_HILO_EN`:
  - Defined: HI/LO fields (`mem_whilo`, `mem_hi`, `mem_lo`) and the accumulate feedback (`hilo_tmp_o`, `cnt_o`) are registered as described above.
  - Undefined: those ports remain on the interface and are tied to constant 0; their registers are not built. GPR and memory fields behave identically in both builds.

## Structure
- Shared `Defines.v` holds: `Stop`/`NotStop`, `RstEnable`, `WriteEnable`/`WriteDisable`, `ZeroWord`, and the default widths.
- The stall-decode helper goes in a sub-module `stage_ctl`:
  - Inputs: `rst`, `flush_i`, the two stall bits.
  - Output: a one-hot action {rst_clr, flush_clr, bubble, advance, hold}.
  - Reusable by the other stage registers.

## Test plan
- Reset then Advance: assert `rst`=1 for 2 cycles → all outputs 0. Then `ex_we`=1, `ex_waddr`=5'h1F, `ex_wdata`=32'hDEADBEEF with stall=0 → next cycle `mem_*` match and `mem_valid`=1.
- Bubble: `stall_i`=6'b000010 (STAGE=2) with `ex_cnt`=2'b01, `ex_hilo_tmp`=64'h0000_0001_0000_0002 → `mem_we`=0, `mem_valid`=0, `cnt_o`=1, `hilo_tmp_o` equals the input.
- Hold: `stall_i`=6'b000110 for 3 cycles while the `ex_*` inputs change → outputs are frozen at the pre-stall values.
- Flush over stall: `flush_i`=1 with `stall_i`=6'b000110 → all outputs 0 on the next edge, including `cnt_o`.
- Two-cycle MADD: a Bubble cycle followed by an Advance cycle with `ex_whilo`=1, `ex_hi`=32'h1, `ex_lo`=32'h2 → `mem_hi`=1, `mem_lo`=2, `cnt_o` returns to 0.
- Build without `EX_MEM_HILO_EN`: repeat the MADD scenario → `mem_whilo`, `mem_hi`, `mem_lo`, `cnt_o` stay 0; GPR fields unchanged from the full build.
